// File: rtl/vram_fetch_sched_if.sv
// Video-memory port and host-requester bundle for the fetch scheduler.
interface vram_fetch_sched_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        host_rvalid;
  logic [7:0]  host_rdata;

  // Scheduler side: drives the memory port and answers the host.
  modport master (
    output mem_addr, mem_rd, mem_we, mem_wdata,
    input  mem_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rvalid, host_rdata
  );

  // Environment side: memory and host requester.
  modport slave (
    input  mem_addr, mem_rd, mem_we, mem_wdata,
    output mem_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vram_fetch_sched.sv
// Time-slot scheduler for the single video-memory port: three display
// fetches per 8-pixel character cell, all remaining slots go to the host.
module vram_fetch_sched #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS_PER_CH = 16,
  parameter logic [15:0] CELL_BASE   = 16'hC000,
  parameter logic [15:0] ATTR_BASE   = 16'h8000,
  parameter logic [15:0] FONT_BASE   = 16'h7000
) (
  input  logic       clkmux,
  input  logic       act_reset,
  input  logic       is_blank,
  input  logic       is_linestart,
  input  logic       frame_start,
  vram_fetch_sched_if.master bus,
  output logic [7:0] glyph_bits,
  output logic [7:0] glyph_attr,
  output logic       glyph_load
);

  localparam logic [2:0] SLOT_CELL  = 3'd0;
  localparam logic [2:0] SLOT_ATTR  = 3'd1;
  localparam logic [2:0] SLOT_FONT  = 3'd2;
  localparam logic [2:0] SLOT_GLYPH = 3'd3;
  localparam logic [2:0] SLOT_PREP  = 3'd6;
  localparam logic [2:0] SLOT_LOAD  = 3'd7;

  logic [2:0]  slot;
  logic        cell_ok;     // current cell fetch started at slot 0 and not yet blanked/aborted
  logic [13:0] text_addr;
  logic [13:0] line_base;
  logic [3:0]  glyph_row;
  logic [7:0]  char_reg;
  logic [7:0]  attr_reg;
  logic [7:0]  font_reg;
  logic [15:0] last_addr;
  logic [7:0]  last_wdata;
  logic [7:0]  rdata_hold;
  logic        host_rd_q;
  logic        disp_fetch;
  logic [15:0] disp_addr;
  logic        ack;

  // Display fetch decode for the current slot.
  always_comb begin
    disp_fetch = 1'b0;
    disp_addr  = last_addr;
    if (!act_reset && !is_blank) begin
      case (slot)
        SLOT_CELL: begin
          disp_fetch = 1'b1;
          disp_addr  = CELL_BASE + {2'b00, text_addr};
        end
        SLOT_ATTR: begin
          disp_fetch = cell_ok;
          disp_addr  = ATTR_BASE + {2'b00, text_addr};
        end
        SLOT_FONT: begin
          disp_fetch = cell_ok;
          disp_addr  = FONT_BASE + {4'b0000, char_reg, glyph_row};
        end
        default: ;
      endcase
    end
  end

  // Memory port mux: display fetch wins, otherwise a waiting host gets the slot.
  always_comb begin
    ack             = !act_reset && bus.host_req && !disp_fetch;
    bus.host_ack    = ack;
    bus.mem_rd      = disp_fetch || (ack && !bus.host_we);
    bus.mem_we      = ack && bus.host_we;
    bus.mem_addr    = disp_fetch ? disp_addr : (ack ? bus.host_addr : last_addr);
    bus.mem_wdata   = (ack && bus.host_we) ? bus.host_wdata : last_wdata;
    bus.host_rvalid = host_rd_q;
    bus.host_rdata  = host_rd_q ? bus.mem_rdata : rdata_hold;
  end

  // Slot counter and per-cell fetch validity.
  always_ff @(posedge clkmux or posedge act_reset) begin
    if (act_reset) begin
      slot    <= '0;
      cell_ok <= 1'b0;
    end else begin
      slot <= is_linestart ? '0 : slot + 3'd1;
      if (is_linestart)
        cell_ok <= 1'b0;
      else if (slot == SLOT_CELL)
        cell_ok <= !is_blank;
      else
        cell_ok <= cell_ok && !is_blank;
    end
  end

  // Capture fetched bytes and present the glyph at slot 7.
  always_ff @(posedge clkmux or posedge act_reset) begin
    if (act_reset) begin
      char_reg   <= '0;
      attr_reg   <= '0;
      font_reg   <= '0;
      glyph_bits <= '0;
      glyph_attr <= '0;
      glyph_load <= 1'b0;
    end else begin
      if (cell_ok && slot == SLOT_ATTR)  char_reg <= bus.mem_rdata;
      if (cell_ok && slot == SLOT_FONT)  attr_reg <= bus.mem_rdata;
      if (cell_ok && slot == SLOT_GLYPH) font_reg <= bus.mem_rdata;
      // Registered one slot early so the load pulse and data appear during slot 7.
      glyph_load <= (slot == SLOT_PREP) && cell_ok && !is_blank && !is_linestart;
      if ((slot == SLOT_PREP) && cell_ok && !is_blank && !is_linestart) begin
        glyph_bits <= font_reg;
        glyph_attr <= attr_reg;
      end
    end
  end

  // Text address, line base and glyph row counters.
  always_ff @(posedge clkmux or posedge act_reset) begin
    if (act_reset) begin
      text_addr <= '0;
      line_base <= '0;
      glyph_row <= '0;
    end else if (frame_start) begin
      text_addr <= '0;
      line_base <= '0;
      glyph_row <= '0;
    end else if (is_linestart) begin
      if (glyph_row == 4'(ROWS_PER_CH - 1)) begin
        glyph_row <= '0;
        line_base <= line_base + 14'(COLS);
        text_addr <= line_base + 14'(COLS);
      end else begin
        glyph_row <= glyph_row + 4'd1;
        text_addr <= line_base;
      end
    end else if (slot == SLOT_LOAD && glyph_load) begin
      text_addr <= text_addr + 14'd1;
    end
  end

  // Idle-hold registers and host read return.
  always_ff @(posedge clkmux or posedge act_reset) begin
    if (act_reset) begin
      last_addr  <= '0;
      last_wdata <= '0;
      rdata_hold <= '0;
      host_rd_q  <= 1'b0;
    end else begin
      if (bus.mem_rd || bus.mem_we) last_addr  <= bus.mem_addr;
      if (bus.mem_we)               last_wdata <= bus.mem_wdata;
      if (host_rd_q)                rdata_hold <= bus.mem_rdata;
      host_rd_q <= ack && !bus.host_we;
    end
  end

endmodule

// File: tb/tb_vram_fetch_sched.sv
// Directed bench for vram_fetch_sched: cell fetch/glyph presentation, host
// slot arbitration, blanking, glyph row / line base stepping, 14-bit wrap, reset.
module tb_vram_fetch_sched;

  logic clkmux = 1'b0;
  logic act_reset;
  logic is_blank, is_linestart, frame_start;
  logic is_blank2, is_linestart2, frame_start2;
  logic [7:0] glyph_bits, glyph_attr, glyph_bits2, glyph_attr2;
  logic glyph_load, glyph_load2;

  int n_checks = 0;
  int n_fail   = 0;

  vram_fetch_sched_if u_if ();
  vram_fetch_sched_if u_if2 ();

  vram_fetch_sched u_dut (
    .clkmux       (clkmux),
    .act_reset    (act_reset),
    .is_blank     (is_blank),
    .is_linestart (is_linestart),
    .frame_start  (frame_start),
    .bus          (u_if.master),
    .glyph_bits   (glyph_bits),
    .glyph_attr   (glyph_attr),
    .glyph_load   (glyph_load)
  );

  vram_fetch_sched #(.COLS(16380), .ROWS_PER_CH(1)) u_dut2 (
    .clkmux       (clkmux),
    .act_reset    (act_reset),
    .is_blank     (is_blank2),
    .is_linestart (is_linestart2),
    .frame_start  (frame_start2),
    .bus          (u_if2.master),
    .glyph_bits   (glyph_bits2),
    .glyph_attr   (glyph_attr2),
    .glyph_load   (glyph_load2)
  );

  always #5 clkmux = ~clkmux;

  // Memory model: request latched mid-cycle, applied at the rising edge.
  logic [7:0]  mem [0:65535];
  logic        lat_rd, lat_we;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        mem_ready = 1'b0;

  always @(negedge clkmux) begin
    lat_rd    = u_if.mem_rd;
    lat_we    = u_if.mem_we;
    lat_addr  = u_if.mem_addr;
    lat_wdata = u_if.mem_wdata;
  end

  always @(posedge clkmux) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'hC000] = 8'h41;
      mem[16'h8000] = 8'h1F;
      mem[16'h7410] = 8'h3C;
      mem[16'h7411] = 8'h66;
      mem[16'hC005] = 8'h5A;
      mem[16'hC050] = 8'h42;
      u_if.mem_rdata <= 8'h00;
      mem_ready = 1'b1;
    end else begin
      if (lat_we) mem[lat_addr] <= lat_wdata;
      if (lat_rd) u_if.mem_rdata <= mem[lat_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkmux);
    #1;
  endtask

  initial begin
    logic [13:0] ta;
    act_reset = 1'b1;
    is_blank = 1'b0; is_linestart = 1'b0; frame_start = 1'b0;
    is_blank2 = 1'b1; is_linestart2 = 1'b0; frame_start2 = 1'b0;
    u_if.host_req = 1'b0; u_if.host_we = 1'b0; u_if.host_addr = '0; u_if.host_wdata = '0;
    u_if2.host_req = 1'b0; u_if2.host_we = 1'b0; u_if2.host_addr = '0; u_if2.host_wdata = '0;
    u_if2.mem_rdata = 8'h00;

    // Reset state
    repeat (3) cyc();
    #2;
    check("reset_outputs",
          {u_if.mem_rd, u_if.mem_we, u_if.host_ack, u_if.host_rvalid, u_if.host_rdata,
           u_if.mem_addr, u_if.mem_wdata, glyph_load, glyph_bits, glyph_attr}, 64'h0);

    // Test 1: first cell after reset (c=0 is slot 0)
    cyc(); act_reset = 1'b0; #2;
    check("t1_cell_fetch", {u_if.mem_rd, u_if.mem_we, u_if.mem_addr}, {2'b10, 16'hC000});
    cyc(); #2;
    check("t1_attr_fetch", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'h8000});
    cyc(); #2;
    check("t1_font_fetch", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'h7410});
    cyc(); #2;
    check("t1_idle_hold", {u_if.mem_rd, u_if.mem_we, u_if.mem_addr}, {2'b00, 16'h7410});
    repeat (4) cyc(); #2;
    check("t1_glyph", {glyph_load, glyph_bits, glyph_attr}, {1'b1, 8'h3C, 8'h1F});
    cyc(); #2;
    check("t1_next_cell", {glyph_load, u_if.mem_rd, u_if.mem_addr}, {2'b01, 16'hC001});

    // Test 2: held host read while active (c=16 is slot 0)
    repeat (8) cyc();
    u_if.host_req = 1'b1; u_if.host_we = 1'b0; u_if.host_addr = 16'hC005; #2;
    check("t2_no_ack_slot0", {u_if.host_ack, u_if.mem_addr}, {1'b0, 16'hC002});
    cyc(); #2;
    check("t2_no_ack_slot1", u_if.host_ack, 1'b0);
    cyc(); #2;
    check("t2_no_ack_slot2", u_if.host_ack, 1'b0);
    cyc(); #2;
    check("t2_ack_slot3", {u_if.host_ack, u_if.mem_rd, u_if.mem_we, u_if.mem_addr},
          {3'b110, 16'hC005});
    cyc(); u_if.host_req = 1'b0; #2;
    check("t2_rvalid", {u_if.host_ack, u_if.host_rvalid, u_if.host_rdata}, {2'b01, 8'h5A});
    cyc(); #2;
    check("t2_rdata_held", {u_if.host_rvalid, u_if.host_rdata}, {1'b0, 8'h5A});

    // Test 3: blanking, back-to-back host writes (c=24..31)
    repeat (2) cyc();
    for (int i = 0; i < 8; i++) begin
      cyc();
      is_blank = 1'b1;
      u_if.host_req = 1'b1; u_if.host_we = 1'b1;
      u_if.host_addr = 16'h8000 + 16'(i); u_if.host_wdata = 8'hA0 + 8'(i);
      #2;
      check("t3_blank_write",
            {glyph_load, u_if.host_ack, u_if.mem_we, u_if.mem_rd, u_if.mem_addr, u_if.mem_wdata},
            {4'b0110, 16'h8000 + 16'(i), 8'hA0 + 8'(i)});
    end
    cyc(); is_blank = 1'b0; u_if.host_req = 1'b0; u_if.host_we = 1'b0; #2;
    check("t3_text_addr_held", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'hC003});

    // Test 5: linestart at slot 1 with a host read acked in the same cycle
    repeat (8) cyc(); #2;
    check("t5_cell4_fetch", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'hC004});
    cyc();
    is_linestart = 1'b1; is_blank = 1'b1;
    u_if.host_req = 1'b1; u_if.host_we = 1'b0; u_if.host_addr = 16'h8003; #2;
    check("t5_ack_at_linestart", {u_if.host_ack, u_if.mem_rd, u_if.mem_we, u_if.mem_addr},
          {3'b110, 16'h8003});
    cyc(); is_linestart = 1'b0; is_blank = 1'b0; u_if.host_req = 1'b0; #2;
    check("t5_rvalid_slot0", {u_if.host_rvalid, u_if.host_rdata}, {1'b1, 8'hA3});
    check("t5_restart_fetch", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'hC000});
    cyc(); #2;
    check("t5_rvalid_once", {u_if.host_rvalid, u_if.mem_rd, u_if.mem_addr}, {2'b01, 16'h8000});
    cyc(); #2;
    check("t5_font_row1", {u_if.mem_rd, u_if.mem_addr}, {1'b1, 16'h7411});
    repeat (5) cyc(); #2;
    check("t5_glyph", {glyph_load, glyph_bits, glyph_attr}, {1'b1, 8'h66, 8'hA0});

    // Test 4: 17 scanlines of 2 cells each, frame start on the first
    for (int ln = 0; ln < 17; ln++) begin
      cyc(); is_linestart = 1'b1; frame_start = (ln == 0); is_blank = 1'b1;
      cyc(); is_linestart = 1'b0; frame_start = 1'b0; is_blank = 1'b0; #2;
      check("t4_cell0_addr", {u_if.mem_rd, u_if.mem_addr},
            {1'b1, (ln == 16) ? 16'hC050 : 16'hC000});
      repeat (2) cyc(); #2;
      check("t4_font_addr", {u_if.mem_rd, u_if.mem_addr},
            {1'b1, (ln == 16) ? 16'h7420 : 16'h7410 + 16'(ln)});
      repeat (6) cyc(); #2;
      check("t4_cell1_addr", {u_if.mem_rd, u_if.mem_addr},
            {1'b1, (ln == 16) ? 16'hC051 : 16'hC001});
      repeat (7) cyc();
    end
    cyc(); is_blank = 1'b1;

    // Test 6: line_base 16380, text address wraps within the 14-bit space
    cyc(); frame_start2 = 1'b1; is_linestart2 = 1'b1;
    cyc(); frame_start2 = 1'b0;
    cyc(); is_linestart2 = 1'b0; is_blank2 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ta = 14'(16380 + j);
      #2;
      check("t6_cell_wrap", {u_if2.mem_rd, u_if2.mem_addr}, {1'b1, 16'hC000 + {2'b00, ta}});
      cyc(); #2;
      check("t6_attr_wrap", {u_if2.mem_rd, u_if2.mem_addr}, {1'b1, 16'h8000 + {2'b00, ta}});
      repeat (7) cyc();
    end
    is_blank2 = 1'b1;

    // Mid-operation reset with a held host request
    cyc(); u_if.host_req = 1'b1; u_if.host_we = 1'b0; u_if.host_addr = 16'hC005; #2;
    check("rst_pre_ack", u_if.host_ack, 1'b1);
    #1 act_reset = 1'b1; #1;
    check("rst_async_clear",
          {u_if.host_ack, u_if.mem_rd, u_if.mem_we, u_if.host_rvalid, glyph_load, u_if.mem_addr},
          {5'b00000, 16'h0000});
    cyc(); act_reset = 1'b0; #2;
    check("rst_regrant", {u_if.host_ack, u_if.mem_rd, u_if.mem_addr}, {2'b11, 16'hC005});
    cyc(); u_if.host_req = 1'b0; #2;
    check("rst_rvalid", {u_if.host_rvalid, u_if.host_rdata}, {1'b1, 8'h5A});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
